// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transfer arbiter: FSM state codes,
// watchdog defaults and a small index-width helper.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_XFER  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int TMO_CYC_DEFAULT = 255;
  localparam int TMO_W           = 8;

  // Width of an index into an n-entry vector (at least one bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_xfer_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set request found scanning
// upward from i_rr_ptr (wrapping modulo NREQ) wins.
module rr_pick
  import spi_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_rr_ptr,
  output logic [NREQ-1:0] o_win_onehot,
  output logic [IW-1:0]   o_win_idx,
  output logic            o_win_valid
);

  logic [IW-1:0] w_cand;

  // Scan from the farthest offset down so the nearest hit overwrites.
  always_comb begin
    o_win_onehot = '0;
    o_win_idx    = '0;
    o_win_valid  = 1'b0;
    w_cand       = '0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      w_cand = IW'((int'(i_rr_ptr) + off) % NREQ);
      if (i_req[w_cand]) begin
        o_win_onehot         = '0;
        o_win_onehot[w_cand] = 1'b1;
        o_win_idx            = w_cand;
        o_win_valid          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_xfer_arbiter.sv
// Round-robin arbiter sharing one spi_master among NREQ requesters.
// Optional watchdog abort of stuck transfers: define SPI_ARB_TIMEOUT_EN.
module spi_xfer_arbiter
  import spi_pkg::*;
#(
  parameter int data    = 8,
  parameter int address = 3,
  parameter int NREQ    = 2,
  parameter int TMO_CYC = TMO_CYC_DEFAULT
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         req_wr,
  input  logic [NREQ*address-1:0] req_addr,
  input  logic [NREQ*data-1:0]    req_wdata,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         done,
  output logic [data-1:0]         rdata,
  output logic                    err,
  output logic                    spe,
  output logic                    m_wr_rdbar,
  output logic [address-1:0]      m_addr,
  output logic [data-1:0]         m_wdata,
  input  logic [data-1:0]         m_rdata,
  input  logic                    TXC
);

  localparam int IW = idx_width(NREQ);

  state_t             r_state, w_state_next;
  logic [IW-1:0]      r_rr_ptr, w_rr_ptr_next;
  logic [IW-1:0]      r_lat_idx, w_lat_idx_next;
  logic               r_lat_wr, w_lat_wr_next;
  logic [address-1:0] r_lat_addr, w_lat_addr_next;
  logic [data-1:0]    r_lat_wdata, w_lat_wdata_next;
  logic [NREQ-1:0]    r_gnt, w_gnt_next;
  logic [NREQ-1:0]    r_done, w_done_next;
  logic               r_err, w_err_next;
  logic               r_spe, w_spe_next;
  logic               r_m_wr, w_m_wr_next;
  logic [address-1:0] r_m_addr, w_m_addr_next;
  logic [data-1:0]    r_m_wdata, w_m_wdata_next;
  logic [data-1:0]    r_rdata, w_rdata_next;

  logic [NREQ-1:0]    w_win_onehot;
  logic [IW-1:0]      w_win_idx;
  logic               w_win_valid;
  logic               w_tmo_hit;

  logic [address-1:0] w_addr_arr  [NREQ];
  logic [data-1:0]    w_wdata_arr [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slice
      assign w_addr_arr[gi]  = req_addr[gi*address +: address];
      assign w_wdata_arr[gi] = req_wdata[gi*data +: data];
    end
  endgenerate

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .i_req        (req),
    .i_rr_ptr     (r_rr_ptr),
    .o_win_onehot (w_win_onehot),
    .o_win_idx    (w_win_idx),
    .o_win_valid  (w_win_valid)
  );

`ifdef SPI_ARB_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

  logic [TMO_W-1:0] r_tmo_cnt, w_tmo_cnt_next;

  // Hit on the last permitted XFER cycle so spe stays high exactly TMO_CYC cycles.
  assign w_tmo_hit = (r_tmo_cnt == TMO_LAST);

  always_comb begin
    w_tmo_cnt_next = r_tmo_cnt;
    if (r_state == ST_GRANT) begin
      w_tmo_cnt_next = '0;
    end else if (r_state == ST_XFER && !TXC) begin
      w_tmo_cnt_next = r_tmo_cnt + 1'b1;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= w_tmo_cnt_next;
    end
  end
`else
  assign w_tmo_hit = 1'b0;
`endif

  always_comb begin
    w_state_next     = r_state;
    w_rr_ptr_next    = r_rr_ptr;
    w_lat_idx_next   = r_lat_idx;
    w_lat_wr_next    = r_lat_wr;
    w_lat_addr_next  = r_lat_addr;
    w_lat_wdata_next = r_lat_wdata;
    w_gnt_next       = r_gnt;
    w_done_next      = '0;
    w_err_next       = 1'b0;
    w_spe_next       = r_spe;
    w_m_wr_next      = r_m_wr;
    w_m_addr_next    = r_m_addr;
    w_m_wdata_next   = r_m_wdata;
    w_rdata_next     = r_rdata;

    case (r_state)
      ST_IDLE: begin
        if (w_win_valid) begin
          w_lat_idx_next   = w_win_idx;
          w_lat_wr_next    = req_wr[w_win_idx];
          w_lat_addr_next  = w_addr_arr[w_win_idx];
          w_lat_wdata_next = w_wdata_arr[w_win_idx];
          w_gnt_next       = w_win_onehot;
          w_state_next     = ST_GRANT;
        end
      end
      ST_GRANT: begin
        w_m_wr_next    = r_lat_wr;
        w_m_addr_next  = r_lat_addr;
        w_m_wdata_next = r_lat_wdata;
        w_spe_next     = 1'b1;
        w_state_next   = ST_XFER;
      end
      ST_XFER: begin
        // Read data is captured on writes too; the master always returns a word.
        if (TXC) begin
          w_rdata_next = m_rdata;
          w_spe_next   = 1'b0;
          w_done_next  = r_gnt;
          w_state_next = ST_DONE;
        end else if (w_tmo_hit) begin
          w_spe_next   = 1'b0;
          w_done_next  = r_gnt;
          w_err_next   = 1'b1;
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_gnt_next    = '0;
        w_rr_ptr_next = (r_lat_idx == IW'(NREQ - 1)) ? '0 : r_lat_idx + 1'b1;
        w_state_next  = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_lat_idx   <= '0;
      r_lat_wr    <= 1'b0;
      r_lat_addr  <= '0;
      r_lat_wdata <= '0;
      r_gnt       <= '0;
      r_done      <= '0;
      r_err       <= 1'b0;
      r_spe       <= 1'b0;
      r_m_wr      <= 1'b0;
      r_m_addr    <= '0;
      r_m_wdata   <= '0;
      r_rdata     <= '0;
    end else begin
      r_state     <= w_state_next;
      r_rr_ptr    <= w_rr_ptr_next;
      r_lat_idx   <= w_lat_idx_next;
      r_lat_wr    <= w_lat_wr_next;
      r_lat_addr  <= w_lat_addr_next;
      r_lat_wdata <= w_lat_wdata_next;
      r_gnt       <= w_gnt_next;
      r_done      <= w_done_next;
      r_err       <= w_err_next;
      r_spe       <= w_spe_next;
      r_m_wr      <= w_m_wr_next;
      r_m_addr    <= w_m_addr_next;
      r_m_wdata   <= w_m_wdata_next;
      r_rdata     <= w_rdata_next;
    end
  end

  assign gnt        = r_gnt;
  assign done       = r_done;
  assign err        = r_err;
  assign spe        = r_spe;
  assign m_wr_rdbar = r_m_wr;
  assign m_addr     = r_m_addr;
  assign m_wdata    = r_m_wdata;
  assign rdata      = r_rdata;

endmodule
